decode_stage: RTL and testbench
===============================

# decode_stage

Instruction-decode stage of the five-stage pipelined CPU, between the IF/ID latch and the EX stage. It drives the register-file read addresses and forwards results from MEM and WB over the register-file outputs. It detects load-use hazards and raises a stall, decodes the supported MIPS subset, and holds the ID/EX pipeline register with flush and bubble insertion.

## Interface
- No parameters.
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- i_valid  in  1  IF/ID holds a real instruction
- i_instruction  in  32  IF/ID instruction word
- i_pc_plus4  in  32  IF/ID PC+4
- i_flush  in  1  branch taken in EX; squash current ID instruction
- i_rf_data1, i_rf_data2  in  32  register-file read data (combinational)
- i_ex_mem_read  in  1  instruction now in EX is a load
- i_ex_rd  in  5  destination register of the instruction in EX
- i_mem_reg_write, i_mem_rd, i_mem_result  in  1/5/32  MEM-stage writeback info
- i_wb_reg_write, i_wb_rd, i_wb_data  in  1/5/32  WB-stage writeback info, same values driven into the register file
- o_rf_read_register1, o_rf_read_register2  out  5  instr[25:21], instr[20:16]; combinational
- o_stall  out  1  hold PC and IF/ID this cycle; combinational
- o_ex_valid  out  1  ID/EX holds a real instruction
- o_ex_rs_data, o_ex_rt_data  out  32  forwarded operand values
- o_ex_imm  out  32  extended immediate
- o_ex_shamt  out  5  shift amount
- o_ex_rd  out  5  destination register, 0 if no write
- o_ex_reg_write, o_ex_mem_read, o_ex_mem_write, o_ex_alu_src, o_ex_branch, o_ex_branch_ne  out  1  control bits
- o_ex_alu_op  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLT, 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI
- o_ex_pc_plus4  out  32  PC+4 for branch target
- o_bubble_count  out  16  saturating count of inserted load-use bubbles

## Operation
- Decoded set:
  - R-type (op 0) add/addu→ADD, sub/subu→SUB, and, or, xor, nor, slt, sltu, sll, srl, sra; dest rd.
  - addi/addiu→ADD, slti→SLT, sltiu→SLTU, andi→AND, ori→OR, lui→LUI; dest rt; alu_src=1.
  - lw: ADD, mem_read, dest rt.
  - sw: ADD, mem_write, no write.
  - beq/bne: SUB, branch, branch_ne=1 for bne, no write.
- Any other opcode or funct decodes as a NOP: valid passes through, all write, memory and branch controls are 0.
- Immediate extension:
  - andi/ori: zero-extend.
  - lui: {imm,16'h0}.
  - All other instructions: sign-extend.
- Operand use:
  - rs is used except by sll/srl/sra/lui.
  - rt is used by R-type, sw, beq, bne.
- Forwarding per operand, highest priority first:
  - MEM, if i_mem_reg_write, i_mem_rd≠0 and i_mem_rd matches.
  - WB, if i_wb_reg_write, i_wb_rd≠0 and i_wb_rd matches.
  - Otherwise the register-file data.
  - Register 0 always reads 0.
- Load-use: o_stall=1 iff all of the following hold:
  - i_valid, !i_flush, i_ex_mem_read, i_ex_rd≠0;
  - i_ex_rd equals a used rs or used rt.
- ID/EX update on each edge:
  - i_flush → bubble.
  - else o_stall → bubble, and o_bubble_count increments, saturating at 16'hFFFF.
  - else → latch the decoded instruction with o_ex_valid=i_valid. When i_valid=0, all controls are 0.
- A bubble is o_ex_valid=0 with reg_write, mem_read, mem_write and branch all 0; data fields are don't-care but driven 0.

## Timing
- Reset: every o_ex_* output and o_bubble_count are 0, effective immediately and asynchronously. o_stall is combinational and 0 while i_valid=0.
- Latency: one cycle from IF/ID to ID/EX.
- A stall lasts exactly one cycle per load-use. Next cycle the load is in MEM, the instruction is re-presented by the held IF/ID, and MEM forwarding supplies the value.
- Flush has priority over stall, and stall is suppressed while flushing. A stall is never asserted without i_valid.
- A WB write to the same register in the same cycle is seen through forwarding, not through the register file.
- Reset asserted mid-stall clears the state in the same cycle; no bubble is counted.

## Test plan
- Reset: assert reset with nonzero inputs → all o_ex_* 0, o_bubble_count 0, o_ex_valid 0.
- Forward priority: add $3,$1,$2 with i_rf_data1=1, WB ($1, 32'h22), MEM ($1, 32'h33) → o_ex_rs_data=32'h33. Drop MEM → 32'h22. MEM rd=0 → 32'h22.
- Load-use: EX lw $5, ID add $6,$5,$0 → o_stall=1 for one cycle, bubble latched, count=1. Next cycle forwarded MEM value latched, valid=1.
- No false stall: EX lw $5, ID sll $7,$5,2 → stall only via rt. EX lw $5, ID lui $5,1 → o_stall=0.
- Flush vs stall: load-use condition with i_flush=1 → o_stall=0, bubble latched, count unchanged.
- Decode: ori $4,$0,16'hFFFF → imm 32'h0000FFFF, OR, rd 4. sw → reg_write 0, mem_write 1, imm sign-extended from 16'h8000 to 32'hFFFF8000. Unknown opcode 6'h3F → valid 1, all controls 0.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction-decode stage: register-file addressing, MEM/WB operand
// forwarding, load-use stall detection, MIPS-subset decode and the ID/EX
// pipeline register with flush/bubble insertion and a bubble counter.
module decode_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   input  logic [31:0] i_instruction,
   input  logic [31:0] i_pc_plus4,
   input  logic        i_flush,
   input  logic [31:0] i_rf_data1,
   input  logic [31:0] i_rf_data2,
   input  logic        i_ex_mem_read,
   input  logic [4:0]  i_ex_rd,
   input  logic        i_mem_reg_write,
   input  logic [4:0]  i_mem_rd,
   input  logic [31:0] i_mem_result,
   input  logic        i_wb_reg_write,
   input  logic [4:0]  i_wb_rd,
   input  logic [31:0] i_wb_data,
   output logic [4:0]  o_rf_read_register1,
   output logic [4:0]  o_rf_read_register2,
   output logic        o_stall,
   output logic        o_ex_valid,
   output logic [31:0] o_ex_rs_data,
   output logic [31:0] o_ex_rt_data,
   output logic [31:0] o_ex_imm,
   output logic [4:0]  o_ex_shamt,
   output logic [4:0]  o_ex_rd,
   output logic        o_ex_reg_write,
   output logic        o_ex_mem_read,
   output logic        o_ex_mem_write,
   output logic        o_ex_alu_src,
   output logic        o_ex_branch,
   output logic        o_ex_branch_ne,
   output logic [3:0]  o_ex_alu_op,
   output logic [31:0] o_ex_pc_plus4,
   output logic [15:0] o_bubble_count
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_NOR  = 4'd5;
   localparam logic [3:0] ALU_SLT  = 4'd6;
   localparam logic [3:0] ALU_SLTU = 4'd7;
   localparam logic [3:0] ALU_SLL  = 4'd8;
   localparam logic [3:0] ALU_SRL  = 4'd9;
   localparam logic [3:0] ALU_SRA  = 4'd10;
   localparam logic [3:0] ALU_LUI  = 4'd11;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic        valid;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        alu_src;
      logic        branch;
      logic        branch_ne;
      logic [3:0]  alu_op;
      logic [31:0] pc_plus4;
   } idex_t;

   // Operand bypass: MEM beats WB beats register file; $0 is hard zero.
   function automatic logic [31:0] fwd_operand(
      input logic [4:0]  r,
      input logic [31:0] rf_data,
      input logic        mem_we,
      input logic [4:0]  mem_rd,
      input logic [31:0] mem_val,
      input logic        wb_we,
      input logic [4:0]  wb_rd,
      input logic [31:0] wb_val
   );
      logic [31:0] v;
      if (r == 5'd0) begin
         v = 32'd0;
      end else if (mem_we && (mem_rd != 5'd0) && (mem_rd == r)) begin
         v = mem_val;
      end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == r)) begin
         v = wb_val;
      end else begin
         v = rf_data;
      end
      return v;
   endfunction

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic        rs_used;
   logic        rt_used;
   logic        stall;
   idex_t       dec;
   idex_t       idex_d;
   idex_t       idex_q;
   logic [15:0] bubble_cnt_d;
   logic [15:0] bubble_cnt_q;

   assign opcode = i_instruction[31:26];
   assign funct  = i_instruction[5:0];
   assign rs     = i_instruction[25:21];
   assign rt     = i_instruction[20:16];

   assign o_rf_read_register1 = rs;
   assign o_rf_read_register2 = rt;

   // Decode the instruction word into ALU/memory/branch controls and operands.
   always_comb begin
      dec           = '0;
      dec.valid     = i_valid;
      dec.shamt     = i_instruction[10:6];
      dec.imm       = {{16{i_instruction[15]}}, i_instruction[15:0]};
      dec.pc_plus4  = i_pc_plus4;
      dec.rs_data   = fwd_operand(rs, i_rf_data1, i_mem_reg_write, i_mem_rd, i_mem_result,
                                  i_wb_reg_write, i_wb_rd, i_wb_data);
      dec.rt_data   = fwd_operand(rt, i_rf_data2, i_mem_reg_write, i_mem_rd, i_mem_result,
                                  i_wb_reg_write, i_wb_rd, i_wb_data);
      rs_used       = 1'b1;
      rt_used       = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            rt_used       = 1'b1;
            dec.rd        = i_instruction[15:11];
            dec.reg_write = 1'b1;
            case (funct)
               6'h20, 6'h21: dec.alu_op = ALU_ADD;
               6'h22, 6'h23: dec.alu_op = ALU_SUB;
               6'h24:        dec.alu_op = ALU_AND;
               6'h25:        dec.alu_op = ALU_OR;
               6'h26:        dec.alu_op = ALU_XOR;
               6'h27:        dec.alu_op = ALU_NOR;
               6'h2A:        dec.alu_op = ALU_SLT;
               6'h2B:        dec.alu_op = ALU_SLTU;
               6'h00: begin
                  dec.alu_op = ALU_SLL;
                  rs_used    = 1'b0;
               end
               6'h02: begin
                  dec.alu_op = ALU_SRL;
                  rs_used    = 1'b0;
               end
               6'h03: begin
                  dec.alu_op = ALU_SRA;
                  rs_used    = 1'b0;
               end
               default: begin
                  // Unsupported funct: behaves as a NOP.
                  dec.rd        = 5'd0;
                  dec.reg_write = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec.alu_op    = ALU_ADD;
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_SLTI: begin
            dec.alu_op    = ALU_SLT;
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_SLTIU: begin
            dec.alu_op    = ALU_SLTU;
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_ANDI: begin
            dec.alu_op    = ALU_AND;
            dec.imm       = {16'h0000, i_instruction[15:0]};
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_ORI: begin
            dec.alu_op    = ALU_OR;
            dec.imm       = {16'h0000, i_instruction[15:0]};
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_LUI: begin
            rs_used       = 1'b0;
            dec.alu_op    = ALU_LUI;
            dec.imm       = {i_instruction[15:0], 16'h0000};
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_LW: begin
            dec.alu_op    = ALU_ADD;
            dec.rd        = rt;
            dec.reg_write = 1'b1;
            dec.mem_read  = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_SW: begin
            rt_used       = 1'b1;
            dec.alu_op    = ALU_ADD;
            dec.mem_write = 1'b1;
            dec.alu_src   = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            rt_used       = 1'b1;
            dec.alu_op    = ALU_SUB;
            dec.branch    = 1'b1;
            dec.branch_ne = (opcode == OP_BNE);
         end
         default: begin
            // Unknown opcode: valid passes through with every control cleared.
            dec.alu_op = ALU_ADD;
         end
      endcase
   end

   // Load-use hazard: the load in EX writes a register this instruction reads.
   always_comb begin
      if (i_valid && !i_flush && i_ex_mem_read && (i_ex_rd != 5'd0)) begin
         stall = (rs_used && (rs == i_ex_rd)) || (rt_used && (rt == i_ex_rd));
      end else begin
         stall = 1'b0;
      end
   end

   assign o_stall = stall;

   // Choose the next ID/EX contents: flush and stall insert a bubble.
   always_comb begin
      idex_d       = '0;
      bubble_cnt_d = bubble_cnt_q;
      if (i_flush) begin
         idex_d = '0;
      end else if (stall) begin
         idex_d = '0;
         if (bubble_cnt_q != 16'hFFFF) begin
            bubble_cnt_d = bubble_cnt_q + 16'd1;
         end else begin
            bubble_cnt_d = bubble_cnt_q;
         end
      end else if (i_valid) begin
         idex_d = dec;
      end else begin
         idex_d = '0;
      end
   end

   // ID/EX pipeline register and bubble counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         idex_q       <= '0;
         bubble_cnt_q <= 16'd0;
      end else begin
         idex_q       <= idex_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign o_ex_valid     = idex_q.valid;
   assign o_ex_rs_data   = idex_q.rs_data;
   assign o_ex_rt_data   = idex_q.rt_data;
   assign o_ex_imm       = idex_q.imm;
   assign o_ex_shamt     = idex_q.shamt;
   assign o_ex_rd        = idex_q.rd;
   assign o_ex_reg_write = idex_q.reg_write;
   assign o_ex_mem_read  = idex_q.mem_read;
   assign o_ex_mem_write = idex_q.mem_write;
   assign o_ex_alu_src   = idex_q.alu_src;
   assign o_ex_branch    = idex_q.branch;
   assign o_ex_branch_ne = idex_q.branch_ne;
   assign o_ex_alu_op    = idex_q.alu_op;
   assign o_ex_pc_plus4  = idex_q.pc_plus4;
   assign o_bubble_count = bubble_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: expected ID/EX contents are queued
// when an instruction is presented and compared after the next rising edge.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [31:0] i_instruction;
   logic [31:0] i_pc_plus4;
   logic        i_flush;
   logic [31:0] i_rf_data1;
   logic [31:0] i_rf_data2;
   logic        i_ex_mem_read;
   logic [4:0]  i_ex_rd;
   logic        i_mem_reg_write;
   logic [4:0]  i_mem_rd;
   logic [31:0] i_mem_result;
   logic        i_wb_reg_write;
   logic [4:0]  i_wb_rd;
   logic [31:0] i_wb_data;
   logic [4:0]  o_rf_read_register1;
   logic [4:0]  o_rf_read_register2;
   logic        o_stall;
   logic        o_ex_valid;
   logic [31:0] o_ex_rs_data;
   logic [31:0] o_ex_rt_data;
   logic [31:0] o_ex_imm;
   logic [4:0]  o_ex_shamt;
   logic [4:0]  o_ex_rd;
   logic        o_ex_reg_write;
   logic        o_ex_mem_read;
   logic        o_ex_mem_write;
   logic        o_ex_alu_src;
   logic        o_ex_branch;
   logic        o_ex_branch_ne;
   logic [3:0]  o_ex_alu_op;
   logic [31:0] o_ex_pc_plus4;
   logic [15:0] o_bubble_count;

   decode_stage dut (
      .clk                 (clk),
      .reset               (reset),
      .i_valid             (i_valid),
      .i_instruction       (i_instruction),
      .i_pc_plus4          (i_pc_plus4),
      .i_flush             (i_flush),
      .i_rf_data1          (i_rf_data1),
      .i_rf_data2          (i_rf_data2),
      .i_ex_mem_read       (i_ex_mem_read),
      .i_ex_rd             (i_ex_rd),
      .i_mem_reg_write     (i_mem_reg_write),
      .i_mem_rd            (i_mem_rd),
      .i_mem_result        (i_mem_result),
      .i_wb_reg_write      (i_wb_reg_write),
      .i_wb_rd             (i_wb_rd),
      .i_wb_data           (i_wb_data),
      .o_rf_read_register1 (o_rf_read_register1),
      .o_rf_read_register2 (o_rf_read_register2),
      .o_stall             (o_stall),
      .o_ex_valid          (o_ex_valid),
      .o_ex_rs_data        (o_ex_rs_data),
      .o_ex_rt_data        (o_ex_rt_data),
      .o_ex_imm            (o_ex_imm),
      .o_ex_shamt          (o_ex_shamt),
      .o_ex_rd             (o_ex_rd),
      .o_ex_reg_write      (o_ex_reg_write),
      .o_ex_mem_read       (o_ex_mem_read),
      .o_ex_mem_write      (o_ex_mem_write),
      .o_ex_alu_src        (o_ex_alu_src),
      .o_ex_branch         (o_ex_branch),
      .o_ex_branch_ne      (o_ex_branch_ne),
      .o_ex_alu_op         (o_ex_alu_op),
      .o_ex_pc_plus4       (o_ex_pc_plus4),
      .o_bubble_count      (o_bubble_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] imm;
      logic [4:0]  shamt;
      logic [4:0]  rd;
      logic        rw;
      logic        mr;
      logic        mw;
      logic        as;
      logic        br;
      logic        bne;
      logic [3:0]  op;
      logic [31:0] pc;
      logic [15:0] cnt;
      logic        full;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Single comparison point: count it and report a mismatch.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic exp_t ev(input logic valid, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] imm, input logic [4:0] shamt,
                               input logic [4:0] rd, input logic rw, input logic mr,
                               input logic mw, input logic as, input logic br,
                               input logic bne, input logic [3:0] op,
                               input logic [31:0] pc, input logic [15:0] cnt,
                               input logic full);
      exp_t e;
      e.valid = valid; e.rs = rs; e.rt = rt; e.imm = imm; e.shamt = shamt; e.rd = rd;
      e.rw = rw; e.mr = mr; e.mw = mw; e.as = as; e.br = br; e.bne = bne; e.op = op;
      e.pc = pc; e.cnt = cnt; e.full = full;
      return e;
   endfunction

   function automatic exp_t bubble(input logic [15:0] cnt);
      return ev(1'b0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                4'd0, 32'd0, cnt, 1'b1);
   endfunction

   task automatic compare_idex(input string tag, input exp_t e);
      check_eq({tag, ".valid"}, 32'(o_ex_valid), 32'(e.valid));
      check_eq({tag, ".rd"}, 32'(o_ex_rd), 32'(e.rd));
      check_eq({tag, ".reg_write"}, 32'(o_ex_reg_write), 32'(e.rw));
      check_eq({tag, ".mem_read"}, 32'(o_ex_mem_read), 32'(e.mr));
      check_eq({tag, ".mem_write"}, 32'(o_ex_mem_write), 32'(e.mw));
      check_eq({tag, ".branch"}, 32'(o_ex_branch), 32'(e.br));
      check_eq({tag, ".branch_ne"}, 32'(o_ex_branch_ne), 32'(e.bne));
      check_eq({tag, ".bubbles"}, 32'(o_bubble_count), 32'(e.cnt));
      if (e.full) begin
         check_eq({tag, ".rs_data"}, o_ex_rs_data, e.rs);
         check_eq({tag, ".rt_data"}, o_ex_rt_data, e.rt);
         check_eq({tag, ".imm"}, o_ex_imm, e.imm);
         check_eq({tag, ".shamt"}, 32'(o_ex_shamt), 32'(e.shamt));
         check_eq({tag, ".alu_src"}, 32'(o_ex_alu_src), 32'(e.as));
         check_eq({tag, ".alu_op"}, 32'(o_ex_alu_op), 32'(e.op));
         check_eq({tag, ".pc_plus4"}, o_ex_pc_plus4, e.pc);
      end
   endtask

   // Queue the expectation, clock once, then pop and compare.
   task automatic step(input string tag, input exp_t e);
      exp_t x;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_eq({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         x = sb.pop_front();
         compare_idex(tag, x);
      end
   endtask

   task automatic check_stall(input string tag, input logic exp);
      #1;
      check_eq({tag, ".stall"}, 32'(o_stall), 32'(exp));
   endtask

   task automatic idle_inputs();
      i_valid         = 1'b1;
      i_instruction   = 32'd0;
      i_pc_plus4      = 32'h0000_0200;
      i_flush         = 1'b0;
      i_rf_data1      = 32'h0000_0011;
      i_rf_data2      = 32'h0000_0022;
      i_ex_mem_read   = 1'b0;
      i_ex_rd         = 5'd0;
      i_mem_reg_write = 1'b0;
      i_mem_rd        = 5'd0;
      i_mem_result    = 32'd0;
      i_wb_reg_write  = 1'b0;
      i_wb_rd         = 5'd0;
      i_wb_data       = 32'd0;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held with nonzero inputs.
      idle_inputs();
      reset           = 1'b1;
      i_instruction   = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      i_mem_reg_write = 1'b1; i_mem_rd = 5'd1; i_mem_result = 32'h33;
      i_ex_mem_read   = 1'b1; i_ex_rd = 5'd9;
      @(posedge clk); @(posedge clk); #1;
      compare_idex("reset", bubble(16'd0));

      // Forwarding priority: MEM > WB > register file.
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();
      i_instruction   = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      i_pc_plus4      = 32'h0000_0104;
      i_rf_data1      = 32'd1;
      i_rf_data2      = 32'd5;
      i_wb_reg_write  = 1'b1; i_wb_rd = 5'd1; i_wb_data = 32'h22;
      i_mem_reg_write = 1'b1; i_mem_rd = 5'd1; i_mem_result = 32'h33;
      check_stall("fwd_mem", 1'b0);
      check_eq("rf_addr1", 32'(o_rf_read_register1), 32'd1);
      check_eq("rf_addr2", 32'(o_rf_read_register2), 32'd2);
      step("fwd_mem", ev(1'b1, 32'h33, 32'd5, 32'h1820, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 4'd0, 32'h104, 16'd0, 1'b1));
      @(negedge clk);
      i_mem_reg_write = 1'b0;
      step("fwd_wb", ev(1'b1, 32'h22, 32'd5, 32'h1820, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 4'd0, 32'h104, 16'd0, 1'b1));
      @(negedge clk);
      i_mem_reg_write = 1'b1; i_mem_rd = 5'd0;
      step("fwd_mem_r0", ev(1'b1, 32'h22, 32'd5, 32'h1820, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b0, 4'd0, 32'h104, 16'd0, 1'b1));
      @(negedge clk);
      i_mem_reg_write = 1'b0; i_wb_reg_write = 1'b0;
      step("fwd_rf", ev(1'b1, 32'd1, 32'd5, 32'h1820, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 4'd0, 32'h104, 16'd0, 1'b1));

      // Load-use on rs, then the held instruction picks up the MEM value.
      @(negedge clk);
      idle_inputs();
      i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
      i_instruction = rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h20);
      i_rf_data2    = 32'h77;
      check_stall("lu_rs", 1'b1);
      step("lu_rs", bubble(16'd1));
      @(negedge clk);
      i_ex_mem_read   = 1'b0; i_ex_rd = 5'd0;
      i_mem_reg_write = 1'b1; i_mem_rd = 5'd5; i_mem_result = 32'hDEAD_BEEF;
      check_stall("lu_replay", 1'b0);
      step("lu_replay", ev(1'b1, 32'hDEAD_BEEF, 32'd0, 32'h3020, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0,
                           1'b0, 1'b0, 1'b0, 4'd0, 32'h200, 16'd1, 1'b1));

      // Shifts stall only through rt; lui uses neither operand.
      @(negedge clk);
      idle_inputs();
      i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
      i_instruction = rtype(5'd0, 5'd5, 5'd7, 5'd2, 6'h00);
      check_stall("sll_rt", 1'b1);
      step("sll_rt", bubble(16'd2));
      @(negedge clk);
      i_instruction = rtype(5'd5, 5'd1, 5'd7, 5'd2, 6'h00);
      check_stall("sll_rs", 1'b0);
      step("sll_rs", ev(1'b1, 32'h11, 32'h22, 32'h3880, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0,
                        1'b0, 1'b0, 4'd8, 32'h200, 16'd2, 1'b1));
      @(negedge clk);
      i_instruction = itype(6'h0F, 5'd0, 5'd5, 16'h0001);
      check_stall("lui", 1'b0);
      step("lui", ev(1'b1, 32'd0, 32'h22, 32'h0001_0000, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'd11, 32'h200, 16'd2, 1'b1));

      // Flush wins over a load-use; invalid IF/ID never stalls.
      @(negedge clk);
      i_instruction = rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h20);
      i_flush       = 1'b1;
      check_stall("flush", 1'b0);
      step("flush", bubble(16'd2));
      @(negedge clk);
      i_flush = 1'b0;
      i_valid = 1'b0;
      check_stall("invalid", 1'b0);
      step("invalid", bubble(16'd2));

      // Decode of immediates and controls.
      @(negedge clk);
      idle_inputs();
      i_instruction = itype(6'h0D, 5'd0, 5'd4, 16'hFFFF);
      step("ori", ev(1'b1, 32'd0, 32'h22, 32'h0000_FFFF, 5'd31, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1,
                     1'b0, 1'b0, 4'd3, 32'h200, 16'd2, 1'b1));
      @(negedge clk);
      i_instruction = itype(6'h2B, 5'd1, 5'd2, 16'h8000);
      step("sw", ev(1'b1, 32'h11, 32'h22, 32'hFFFF_8000, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1,
                    1'b0, 1'b0, 4'd0, 32'h200, 16'd2, 1'b1));
      @(negedge clk);
      i_instruction = itype(6'h3F, 5'd1, 5'd2, 16'h1234);
      step("unknown", ev(1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 4'd0, 32'd0, 16'd2, 1'b0));
      @(negedge clk);
      i_instruction = itype(6'h05, 5'd1, 5'd2, 16'hFFFF);
      step("bne", ev(1'b1, 32'h11, 32'h22, 32'hFFFF_FFFF, 5'd31, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b1, 1'b1, 4'd1, 32'h200, 16'd2, 1'b1));
      @(negedge clk);
      i_instruction = itype(6'h23, 5'd1, 5'd8, 16'h0004);
      step("lw", ev(1'b1, 32'h11, 32'h22, 32'h0000_0004, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1,
                    1'b0, 1'b0, 4'd0, 32'h200, 16'd2, 1'b1));

      // Same-cycle WB write to rt reaches EX via forwarding.
      @(negedge clk);
      i_instruction  = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      i_wb_reg_write = 1'b1; i_wb_rd = 5'd2; i_wb_data = 32'hAB;
      step("wb_rt", ev(1'b1, 32'h11, 32'hAB, 32'h1820, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0,
                       1'b0, 1'b0, 4'd0, 32'h200, 16'd2, 1'b1));

      // Asynchronous reset in the middle of a load-use stall.
      @(negedge clk);
      idle_inputs();
      i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
      i_instruction = rtype(5'd5, 5'd0, 5'd6, 5'd0, 6'h20);
      #2;
      reset = 1'b1;
      #1;
      check_eq("async_rst.valid", 32'(o_ex_valid), 32'd0);
      check_eq("async_rst.rd", 32'(o_ex_rd), 32'd0);
      check_eq("async_rst.bubbles", 32'(o_bubble_count), 32'd0);
      @(posedge clk);
      #1;
      check_eq("rst_hold.bubbles", 32'(o_bubble_count), 32'd0);
      check_eq("rst_hold.valid", 32'(o_ex_valid), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle_inputs();

      check_eq("sb_drained", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
